id_ex_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_ctl_dec.sv | 37 +++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions for the ID/EX stage and its control decoder.
//   - alu_ctl_e : 4-bit ALU control word {a_invert, b_invert, operation[1:0]}
//   - ALUOP_*   : 2-bit alu_op encodings produced by the main decoder
//   - FUNCT_*   : R-type function field values understood by the ALU
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctl_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_ctl_dec.sv
// alu_ctl_dec: combinational ALUOp/funct to ALU control word translation.
// Ports:
//   alu_op  in  2  main-decoder ALU operation class
//   funct   in  6  R-type function field (only used when alu_op = R-type)
//   alu_ctl out 4  ALU control word
//   illegal out 1  R-type funct not supported by the ALU (alu_ctl forced to AND)
module alu_ctl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       illegal
);

  always_comb begin
    alu_ctl = ALU_AND;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_OR:  alu_ctl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALU_ADD;
          FUNCT_SUB: alu_ctl = ALU_SUB;
          FUNCT_AND: alu_ctl = ALU_AND;
          FUNCT_OR:  alu_ctl = ALU_OR;
          FUNCT_SLT: alu_ctl = ALU_SLT;
          FUNCT_NOR: alu_ctl = ALU_NOR;
          default:   illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register in front of the 32-bit ALU.
// Captures decoded operands/control under a valid/ready handshake, registers the
// ALU control word, and presents forwarded operands and store data to execute.
//
// Optional feature macro: ID_EX_STAGE_FWD_EN
//   defined   : EX/MEM and MEM/WB forwarding muxes plus operand refresh while stalled
//   undefined : operands come straight from the held registers; forwarding inputs ignored
//
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready            decode-side handshake
//   rs_data, rt_data, imm32      operand values
//   rs_addr, rt_addr, dst_addr   register numbers
//   alu_op, funct, alu_src       ALU control inputs
//   reg_write, mem_read, mem_write, mem_to_reg   pass-through control
//   flush                        kill held and incoming entry
//   exmem_*, memwb_*             forwarding sources
//   out_valid/out_ready          execute-side handshake
//   alu_a, alu_b, alu_ctl, store_data           execute operands
//   dst_q, *_q                   registered pass-through
//   illegal                      held entry carries an undecodable funct
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  rs_data,
  input  logic [W-1:0]  rt_data,
  input  logic [W-1:0]  imm32,
  input  logic [RA-1:0] rs_addr,
  input  logic [RA-1:0] rt_addr,
  input  logic [RA-1:0] dst_addr,
  input  logic [1:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic          alu_src,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          mem_to_reg,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RA-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RA-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_ctl,
  output logic [W-1:0]  store_data,
  output logic [RA-1:0] dst_q,
  output logic          reg_write_q,
  output logic          mem_read_q,
  output logic          mem_write_q,
  output logic          mem_to_reg_q,
  output logic          illegal
);

  logic [3:0]    dec_ctl;
  logic          dec_illegal;
  logic          valid_q;
  logic [W-1:0]  rs_q;
  logic [W-1:0]  rt_q;
  logic [W-1:0]  imm_q;
  logic [RA-1:0] rs_addr_q;
  logic [RA-1:0] rt_addr_q;
  logic          alu_src_q;
  logic [W-1:0]  rs_fwd;
  logic [W-1:0]  rt_fwd;
  logic          load;

  alu_ctl_dec u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_ctl (dec_ctl),
    .illegal (dec_illegal)
  );

  assign in_ready  = !valid_q || out_ready || flush;
  // A flushed incoming entry is still handshaken (in_ready=1) but never loaded.
  assign load      = in_valid && in_ready && !flush;
  assign out_valid = valid_q;

`ifdef ID_EX_STAGE_FWD_EN
  // EX/MEM is the younger producer, so it wins; register 0 is hardwired zero.
  always_comb begin
    rs_fwd = rs_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_addr_q)
      rs_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_addr_q)
      rs_fwd = memwb_wdata;
  end

  always_comb begin
    rt_fwd = rt_q;
    if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_addr_q)
      rt_fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_addr_q)
      rt_fwd = memwb_wdata;
  end
`else
  assign rs_fwd = rs_q;
  assign rt_fwd = rt_q;

  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_wdata,
                        rs_addr_q, rt_addr_q};
`endif

  assign alu_a      = rs_fwd;
  assign store_data = rt_fwd;
  assign alu_b      = alu_src_q ? imm_q : rt_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      alu_src_q    <= 1'b0;
      alu_ctl      <= ALU_AND;
      illegal      <= 1'b0;
      dst_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q      <= 1'b1;
      rs_q         <= rs_data;
      rt_q         <= rt_data;
      imm_q        <= imm32;
      rs_addr_q    <= rs_addr;
      rt_addr_q    <= rt_addr;
      alu_src_q    <= alu_src;
      alu_ctl      <= dec_ctl;
      illegal      <= dec_illegal;
      dst_q        <= dst_addr;
      reg_write_q  <= reg_write;
      mem_read_q   <= mem_read;
      mem_write_q  <= mem_write;
      mem_to_reg_q <= mem_to_reg;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
`ifdef ID_EX_STAGE_FWD_EN
    // Stalled: capture forwarded values so they survive the producer retiring.
    else if (valid_q) begin
      rs_q <= rs_fwd;
      rt_q <= rt_fwd;
    end
`endif
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  rs_data, rt_data, imm32;
  logic [RA-1:0] rs_addr, rt_addr, dst_addr;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic          alu_src, reg_write, mem_read, mem_write, mem_to_reg, flush;
  logic          exmem_reg_write, memwb_reg_write;
  logic [RA-1:0] exmem_rd, memwb_rd;
  logic [W-1:0]  exmem_result, memwb_wdata;
  logic          out_valid, out_ready;
  logic [W-1:0]  alu_a, alu_b, store_data;
  logic [3:0]    alu_ctl;
  logic [RA-1:0] dst_q;
  logic          reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, illegal;

  always #5 clk = ~clk;

  id_ex_stage #(.W(W), .RA(RA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dst_addr(dst_addr),
    .alu_op(alu_op), .funct(funct), .alu_src(alu_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .store_data(store_data),
    .dst_q(dst_q), .reg_write_q(reg_write_q), .mem_read_q(mem_read_q),
    .mem_write_q(mem_write_q), .mem_to_reg_q(mem_to_reg_q), .illegal(illegal)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  typedef struct {
    bit            valid;
    bit [W-1:0]    rs, rt, imm;
    bit [RA-1:0]   rsa, rta, dst;
    bit            src, rw, mr, mw, m2r, ill;
    bit [3:0]      ctl;
  } entry_t;
  entry_t m;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [4:0] spec_ctl(input bit [1:0] op, input bit [5:0] f);
    if (op == 2'd0) return 5'b0_0010;
    if (op == 2'd1) return 5'b0_0110;
    if (op == 2'd3) return 5'b0_0001;
    case (f)
      6'd32:   return 5'b0_0010;
      6'd34:   return 5'b0_0110;
      6'd36:   return 5'b0_0000;
      6'd37:   return 5'b0_0001;
      6'd42:   return 5'b0_0111;
      6'd39:   return 5'b0_1100;
      default: return 5'b1_0000;
    endcase
  endfunction

  function automatic bit [W-1:0] fwd_val(input bit [RA-1:0] a, input bit [W-1:0] q);
`ifdef ID_EX_STAGE_FWD_EN
    if (a != 0 && exmem_reg_write && exmem_rd == a) return exmem_result;
    if (a != 0 && memwb_reg_write && memwb_rd == a) return memwb_wdata;
`endif
    return q;
  endfunction

  task automatic model_reset();
    m = '{default: 0};
  endtask

  task automatic cycle(input string tag);
    bit       rdy;
    bit [4:0] d;
    #1;
    rdy = !m.valid || out_ready || flush;
    chk({tag, "/in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    chk({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, m.valid});
    if (m.valid) begin
      chk({tag, "/alu_a"}, alu_a, fwd_val(m.rsa, m.rs));
      chk({tag, "/alu_b"}, alu_b, m.src ? m.imm : fwd_val(m.rta, m.rt));
      chk({tag, "/store_data"}, store_data, fwd_val(m.rta, m.rt));
      chk({tag, "/alu_ctl"}, {28'd0, alu_ctl}, {28'd0, m.ctl});
      chk({tag, "/illegal"}, {31'd0, illegal}, {31'd0, m.ill});
      chk({tag, "/ctrl"}, {24'd0, dst_q, reg_write_q, mem_read_q, mem_write_q},
          {24'd0, m.dst, m.rw, m.mr, m.mw});
      chk({tag, "/m2r"}, {31'd0, mem_to_reg_q}, {31'd0, m.m2r});
    end
    if (flush) begin
      m.valid = 0;
    end else if (in_valid && rdy) begin
      d = spec_ctl(alu_op, funct);
      m = '{valid: 1, rs: rs_data, rt: rt_data, imm: imm32, rsa: rs_addr, rta: rt_addr,
            dst: dst_addr, src: alu_src, rw: reg_write, mr: mem_read, mw: mem_write,
            m2r: mem_to_reg, ill: d[4], ctl: d[3:0]};
    end else if (out_ready) begin
      m.valid = 0;
    end else if (m.valid) begin
`ifdef ID_EX_STAGE_FWD_EN
      m.rs = fwd_val(m.rsa, m.rs);
      m.rt = fwd_val(m.rta, m.rt);
`endif
    end
    @(posedge clk);
    #1;
    $display("[%0t] %s in_v=%0b in_r=%0b out_v=%0b ctl=%b a=%0h b=%0h", $time, tag,
             in_valid, in_ready, out_valid, alu_ctl, alu_a, alu_b);
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs_data = 0; rt_data = 0; imm32 = 0;
    rs_addr = 0; rt_addr = 0; dst_addr = 0; alu_op = 0; funct = 0;
    alu_src = 0; reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    flush = 0; out_ready = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "/out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "/alu_ctl"}, {28'd0, alu_ctl}, 32'd0);
    chk({tag, "/illegal"}, {31'd0, illegal}, 32'd0);
    chk({tag, "/ctrl"}, {23'd0, dst_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q}, 32'd0);
    chk({tag, "/alu_a"}, alu_a, 32'd0);
    chk({tag, "/alu_b"}, alu_b, 32'd0);
    chk({tag, "/store_data"}, store_data, 32'd0);
  endtask

  initial begin
    bit [5:0] good_f [6];
    good_f = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39};

    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    in_valid = 1; alu_op = 2'b10; funct = 6'b100010; rs_data = 5; rt_data = 3;
    rs_addr = 1; rt_addr = 2; dst_addr = 3; reg_write = 1; out_ready = 1;
    cycle("sub_load");
    in_valid = 0;
    chk("sub/ctl", {28'd0, alu_ctl}, 32'h6);
    chk("sub/a", alu_a, 32'd5);
    chk("sub/b", alu_b, 32'd3);
    cycle("sub_hold");

    in_valid = 1; alu_op = 2'b00; rs_addr = 8; rt_addr = 9; rs_data = 32'h11; rt_data = 32'h22;
    cycle("fwd_load");
    in_valid = 0; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 8; exmem_result = 32'h1234;
    memwb_reg_write = 1; memwb_rd = 8; memwb_wdata = 32'h5678;
    cycle("fwd_both");
    out_ready = 1;
    cycle("fwd_drain");

    in_valid = 1; rs_addr = 0; rs_data = 32'h77;
    exmem_rd = 0; memwb_rd = 0;
    cycle("r0_load");
    in_valid = 0; out_ready = 0;
    cycle("r0_hold");
    out_ready = 1;
    cycle("r0_drain");

    exmem_reg_write = 0; memwb_reg_write = 0;
    in_valid = 1; rs_addr = 4; rs_data = 32'h1; out_ready = 1;
    cycle("stall_load");
    in_valid = 1; rs_data = 32'h99; rs_addr = 5; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAA;
    cycle("stall_1");
    exmem_reg_write = 0; exmem_result = 0;
    cycle("stall_2");
    cycle("stall_3");
    out_ready = 1;
    cycle("stall_release");
    in_valid = 0;
    cycle("stall_next");

    in_valid = 1; rs_data = 32'h3; out_ready = 0;
    cycle("pre_flush");
    flush = 1;
    cycle("flush");
    flush = 0; in_valid = 0;
    chk("flush/out_valid", {31'd0, out_valid}, 32'd0);
    cycle("post_flush");

    in_valid = 1; alu_op = 2'b10; funct = 6'b000000; out_ready = 1;
    cycle("illegal_load");
    in_valid = 0;
    chk("illegal/flag", {31'd0, illegal}, 32'd1);
    chk("illegal/ctl", {28'd0, alu_ctl}, 32'd0);
    cycle("illegal_hold");

    in_valid = 1; alu_op = 2'b01; out_ready = 0; rs_data = 32'hDEAD;
    cycle("rst_load");
    in_valid = 0;
    #2 rst = 1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(2) != 0);
      flush      = ($urandom_range(15) == 0);
      rs_data    = $urandom; rt_data = $urandom; imm32 = $urandom;
      rs_addr    = RA'($urandom_range(3)); rt_addr = RA'($urandom_range(3));
      dst_addr   = RA'($urandom);
      alu_op     = 2'($urandom);
      funct      = ($urandom_range(7) == 0) ? 6'($urandom) : good_f[$urandom_range(5)];
      alu_src    = 1'($urandom); reg_write = 1'($urandom); mem_read = 1'($urandom);
      mem_write  = 1'($urandom); mem_to_reg = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = RA'($urandom_range(3)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = RA'($urandom_range(3)); memwb_wdata = $urandom;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
